wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
- Writeback stage: the write side of the register file that the decode stage reads.
- Accepts retiring instructions from MEM over a valid/ready handshake and selects the writeback source: ALU result, PC+4, or load data.
- For loads, waits for the data-memory read return, then aligns and sign/zero-extends the data.
- Drives the regfile write port (regfile_wen / rd_addr_in / rd_data_in of decode) with registered, single-cycle write pulses.

Parameters:
- DWIDTH, `RF_DWIDTH (32): register/data width.
- AWIDTH, `RF_AWIDTH (5): register address width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset.
- in_valid  in  1  MEM presents a retiring instruction.
- in_ready  out  1  stage can accept.
- in_rd_wen  in  1  instruction writes rd.
- in_rd_addr  in  AWIDTH  destination register.
- in_wb_sel  in  2  00 ALU, 01 LOAD, 10 PC+4, 11 ALU.
- in_alu_result  in  DWIDTH  ALU result.
- in_pc_plus4  in  DWIDTH  link value.
- in_funct3  in  3  load type.
- in_addr_lo  in  2  load byte offset, i.e. address[1:0].
- dmem_rvalid  in  1  load data valid.
- dmem_rdata  in  DWIDTH  raw aligned word.
- regfile_wen  out  1  regfile write enable.
- rd_addr_out  out  AWIDTH  write address.
- rd_data_out  out  DWIDTH  write data.
- load_pending  out  1  a load is awaiting data.
- pending_rd  out  AWIDTH  rd of the pending load, 0 when none.

Behaviour:
- States: IDLE, WAIT_LOAD.
- Reset (rst==0 at a clk edge):
  - state=IDLE; regfile_wen, rd_addr_out, rd_data_out, pending_rd = 0.
  - Latched load info is cleared.
  - in_ready=0 while rst==0.
  - Reset during WAIT_LOAD abandons the load; no write occurs.
- in_ready = rst & (state==IDLE). This is combinational from the state register.
- Accept = in_valid & in_ready.
- Non-load accept in cycle N:
  - Cycle N+1: regfile_wen=1 for exactly one cycle, rd_addr_out=in_rd_addr, rd_data_out = ALU result or PC+4 per in_wb_sel.
  - Back-to-back non-load accepts give one write per cycle, so throughput is 1/cycle.
- Load accept in cycle N:
  - Latch rd, rd_wen, funct3 and addr_lo.
  - State becomes WAIT_LOAD at N+1; load_pending=1 and pending_rd=rd from N+1.
- In WAIT_LOAD, the first cycle M with dmem_rvalid=1 completes the load:
  - Cycle M+1: regfile_wen=1 with extended data, state=IDLE, load_pending=0, in_ready=1.
  - Minimum load occupancy is 2 cycles, so a new accept is possible at M+1.
- dmem_rvalid while IDLE is ignored.
- Load extension:
  - funct3 000 LB: byte addr_lo, sign-extended.
  - funct3 100 LBU: byte addr_lo, zero-extended.
  - funct3 001 LH: halfword addr_lo[1], sign-extended.
  - funct3 101 LHU: halfword addr_lo[1], zero-extended.
  - funct3 010 LW: full word.
  - Any other funct3: treated as LW.
- x0 and rd_wen gating:
  - If rd_addr==0 or rd_wen==0, regfile_wen stays 0, but the instruction still occupies the stage and still retires.
  - rd_addr_out/rd_data_out still update, for observability.
- When regfile_wen=0, rd_addr_out/rd_data_out hold their previous values.
- Simultaneous dmem_rvalid and in_valid during WAIT_LOAD: in_valid is not accepted that cycle because in_ready=0.

Optional Feature:
- Macro: WB_RETIRE_CNT_EN.
- Defined:
  - Adds output instret (64 bits), reset to 0.
  - Increments by 1 in the cycle after every retirement: non-load accept, or load completion. Includes x0/no-write instructions.
  - Wraps modulo 2^64.
- Undefined: no port, no counter logic.

Test Plan:
- Reset with in_valid=1 → in_ready=0, regfile_wen=0, outputs 0. Release → in_ready=1 the next cycle.
- ALU writes x5=0x1234 then x6=0xABCD in consecutive cycles, wb_sel=00 → regfile_wen high two consecutive cycles with correct addr/data; in_ready stays 1.
- LB x7, addr_lo=2, dmem_rdata=0x12F45678 after a 3-cycle wait:
  - load_pending=1, pending_rd=7 during the wait; in_ready=0.
  - Then a write of x7=0xFFFFFFF4.
  - Repeat with LBU → 0x000000F4; LHU addr_lo=2 → 0x000012F4.
- JAL with rd=0, wb_sel=10 → no regfile_wen. With WB_RETIRE_CNT_EN, instret increments by 1.
- Load pending, rst asserted before dmem_rvalid → no write, state IDLE, load_pending=0. A later dmem_rvalid is ignored.
- dmem_rvalid pulses while IDLE → no write, no state change.

Source files
------------

// File: rtl/wb_stage.sv
// Writeback stage: retires MEM instructions into the register file, waiting on
// dmem for loads. Optional retirement counter behind macro WB_RETIRE_CNT_EN.

`ifndef RF_DWIDTH
`define RF_DWIDTH 32
`endif
`ifndef RF_AWIDTH
`define RF_AWIDTH 5
`endif

module wb_stage #(
  parameter int unsigned DWIDTH = `RF_DWIDTH,
  parameter int unsigned AWIDTH = `RF_AWIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_rd_wen,
  input  logic [AWIDTH-1:0] in_rd_addr,
  input  logic [1:0]        in_wb_sel,
  input  logic [DWIDTH-1:0] in_alu_result,
  input  logic [DWIDTH-1:0] in_pc_plus4,
  input  logic [2:0]        in_funct3,
  input  logic [1:0]        in_addr_lo,
  input  logic              dmem_rvalid,
  input  logic [DWIDTH-1:0] dmem_rdata,
  output logic              regfile_wen,
  output logic [AWIDTH-1:0] rd_addr_out,
  output logic [DWIDTH-1:0] rd_data_out,
  output logic              load_pending,
  output logic [AWIDTH-1:0] pending_rd
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [63:0]       instret
`endif
);

  localparam logic [1:0] WB_SEL_LOAD = 2'b01;
  localparam logic [1:0] WB_SEL_PC4  = 2'b10;

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_LOAD = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic                wen_q, wen_d;
  logic [AWIDTH-1:0]   rd_addr_q, rd_addr_d;
  logic [DWIDTH-1:0]   rd_data_q, rd_data_d;
  logic [AWIDTH-1:0]   ld_rd_q, ld_rd_d;
  logic                ld_wen_q, ld_wen_d;
  logic [2:0]          ld_funct3_q, ld_funct3_d;
  logic [1:0]          ld_addr_lo_q, ld_addr_lo_d;
  logic                accept;
  logic                retire;
  logic [7:0]          load_byte;
  logic [15:0]         load_half;
  logic [DWIDTH-1:0]   load_ext;

  assign in_ready     = rst & (state_q == IDLE);
  assign accept       = in_valid & in_ready;
  assign regfile_wen  = wen_q;
  assign rd_addr_out  = rd_addr_q;
  assign rd_data_out  = rd_data_q;
  assign load_pending = (state_q == WAIT_LOAD);
  assign pending_rd   = ld_rd_q;

  // Lane select and extension of the returned load word
  always_comb begin
    load_byte = dmem_rdata[{ld_addr_lo_q, 3'b000} +: 8];
    load_half = dmem_rdata[{ld_addr_lo_q[1], 4'b0000} +: 16];
    case (ld_funct3_q)
      3'b000:  load_ext = {{(DWIDTH-8){load_byte[7]}}, load_byte};
      3'b100:  load_ext = DWIDTH'(load_byte);
      3'b001:  load_ext = {{(DWIDTH-16){load_half[15]}}, load_half};
      3'b101:  load_ext = DWIDTH'(load_half);
      default: load_ext = dmem_rdata;
    endcase
  end

  // Next-state and writeback selection
  always_comb begin
    state_d      = state_q;
    wen_d        = 1'b0;
    rd_addr_d    = rd_addr_q;
    rd_data_d    = rd_data_q;
    ld_rd_d      = ld_rd_q;
    ld_wen_d     = ld_wen_q;
    ld_funct3_d  = ld_funct3_q;
    ld_addr_lo_d = ld_addr_lo_q;
    retire       = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (in_wb_sel == WB_SEL_LOAD) begin
            ld_rd_d      = in_rd_addr;
            ld_wen_d     = in_rd_wen;
            ld_funct3_d  = in_funct3;
            ld_addr_lo_d = in_addr_lo;
            state_d      = WAIT_LOAD;
          end else begin
            wen_d     = in_rd_wen & (in_rd_addr != '0);
            rd_addr_d = in_rd_addr;
            rd_data_d = (in_wb_sel == WB_SEL_PC4) ? in_pc_plus4 : in_alu_result;
            retire    = 1'b1;
          end
        end
      end
      WAIT_LOAD: begin
        if (dmem_rvalid) begin
          wen_d     = ld_wen_q & (ld_rd_q != '0);
          rd_addr_d = ld_rd_q;
          rd_data_d = load_ext;
          ld_rd_d   = '0;
          state_d   = IDLE;
          retire    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      wen_q        <= 1'b0;
      rd_addr_q    <= '0;
      rd_data_q    <= '0;
      ld_rd_q      <= '0;
      ld_wen_q     <= 1'b0;
      ld_funct3_q  <= '0;
      ld_addr_lo_q <= '0;
    end else begin
      state_q      <= state_d;
      wen_q        <= wen_d;
      rd_addr_q    <= rd_addr_d;
      rd_data_q    <= rd_data_d;
      ld_rd_q      <= ld_rd_d;
      ld_wen_q     <= ld_wen_d;
      ld_funct3_q  <= ld_funct3_d;
      ld_addr_lo_q <= ld_addr_lo_d;
    end
  end

`ifdef WB_RETIRE_CNT_EN
  logic [63:0] instret_q, instret_d;

  assign instret   = instret_q;
  assign instret_d = retire ? instret_q + 64'd1 : instret_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      instret_q <= '0;
    end else begin
      instret_q <= instret_d;
    end
  end
`else
  logic unused_retire;
  assign unused_retire = retire;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed plan steps plus a randomized
// instruction mix checked against an arithmetic load/writeback model.

module tb_wb_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_rd_wen;
  logic [4:0]  in_rd_addr;
  logic [1:0]  in_wb_sel;
  logic [31:0] in_alu_result;
  logic [31:0] in_pc_plus4;
  logic [2:0]  in_funct3;
  logic [1:0]  in_addr_lo;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        regfile_wen;
  logic [4:0]  rd_addr_out;
  logic [31:0] rd_data_out;
  logic        load_pending;
  logic [4:0]  pending_rd;
`ifdef WB_RETIRE_CNT_EN
  logic [63:0] instret;
`endif

  int          n_tests;
  int          n_fail;
  logic [63:0] exp_instret;
  logic [4:0]  last_addr;
  logic [31:0] last_data;

  wb_stage #(.DWIDTH(32), .AWIDTH(5)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_rd_wen     (in_rd_wen),
    .in_rd_addr    (in_rd_addr),
    .in_wb_sel     (in_wb_sel),
    .in_alu_result (in_alu_result),
    .in_pc_plus4   (in_pc_plus4),
    .in_funct3     (in_funct3),
    .in_addr_lo    (in_addr_lo),
    .dmem_rvalid   (dmem_rvalid),
    .dmem_rdata    (dmem_rdata),
    .regfile_wen   (regfile_wen),
    .rd_addr_out   (rd_addr_out),
    .rd_data_out   (rd_data_out),
    .load_pending  (load_pending),
    .pending_rd    (pending_rd)
`ifdef WB_RETIRE_CNT_EN
    ,
    .instret       (instret)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference load result from plain shifts and arithmetic sign handling
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input int lo, input logic [31:0] word);
    int unsigned b;
    int unsigned h;
    int          v;
    b = (word >> (8 * lo)) & 32'hFF;
    h = (word >> (16 * (lo / 2))) & 32'hFFFF;
    case (f3)
      3'd0: begin v = int'(b); if (v >= 128) v = v - 256; return 32'(v); end
      3'd4: return 32'(b);
      3'd1: begin v = int'(h); if (v >= 32768) v = v - 65536; return 32'(v); end
      3'd5: return 32'(h);
      default: return word;
    endcase
  endfunction

  task automatic idle_inputs();
    in_valid      = 1'b0;
    in_rd_wen     = 1'b0;
    in_rd_addr    = 5'($urandom);
    in_wb_sel     = 2'b00;
    in_alu_result = $urandom;
    in_pc_plus4   = $urandom;
    in_funct3     = 3'($urandom);
    in_addr_lo    = 2'($urandom);
    dmem_rvalid   = 1'b0;
    dmem_rdata    = $urandom;
  endtask

  task automatic present(input logic [4:0] rd, input logic wen, input logic [1:0] sel,
                         input logic [31:0] alu, input logic [31:0] pc,
                         input logic [2:0] f3, input logic [1:0] lo);
    in_valid      = 1'b1;
    in_rd_wen     = wen;
    in_rd_addr    = rd;
    in_wb_sel     = sel;
    in_alu_result = alu;
    in_pc_plus4   = pc;
    in_funct3     = f3;
    in_addr_lo    = lo;
  endtask

  task automatic expect_write(input string tag, input logic [4:0] rd, input logic wen,
                              input logic [31:0] data);
    chk({tag, "_wen"}, 64'(regfile_wen), 64'(wen && rd != 5'd0));
    chk({tag, "_addr"}, 64'(rd_addr_out), 64'(rd));
    chk({tag, "_data"}, 64'(rd_data_out), 64'(data));
    last_addr = rd;
    last_data = data;
  endtask

  task automatic do_nonload(input string tag, input logic [4:0] rd, input logic wen,
                            input logic [1:0] sel, input logic [31:0] alu, input logic [31:0] pc);
    present(rd, wen, sel, alu, pc, 3'($urandom), 2'($urandom));
    chk({tag, "_ready"}, 64'(in_ready), 64'd1);
    tick();
    idle_inputs();
    exp_instret++;
    expect_write(tag, rd, wen, (sel == 2'b10) ? pc : alu);
    tick();
    chk({tag, "_pulse"}, 64'(regfile_wen), 64'd0);
    chk({tag, "_hold"}, 64'({rd_addr_out, rd_data_out}), 64'({last_addr, last_data}));
  endtask

  task automatic do_load(input string tag, input logic [4:0] rd, input logic wen,
                         input logic [2:0] f3, input logic [1:0] lo,
                         input logic [31:0] word, input int waitc);
    present(rd, wen, 2'b01, $urandom, $urandom, f3, lo);
    tick();
    // A competing instruction stays presented while the load is outstanding
    present(5'd31, 1'b1, 2'b00, 32'hDEAD0000, 32'h0, 3'd0, 2'd0);
    for (int i = 0; i < waitc; i++) begin
      dmem_rvalid = 1'b0;
      dmem_rdata  = $urandom;
      chk({tag, "_pend"}, 64'(load_pending), 64'd1);
      chk({tag, "_prd"}, 64'(pending_rd), 64'(rd));
      chk({tag, "_nrdy"}, 64'(in_ready), 64'd0);
      tick();
      chk({tag, "_nowen"}, 64'(regfile_wen), 64'd0);
    end
    dmem_rvalid = 1'b1;
    dmem_rdata  = word;
    chk({tag, "_pend_last"}, 64'(load_pending), 64'd1);
    tick();
    idle_inputs();
    exp_instret++;
    expect_write(tag, rd, wen, ref_load(f3, int'(lo), word));
    chk({tag, "_done"}, 64'({load_pending, pending_rd, in_ready}), 64'({1'b0, 5'd0, 1'b1}));
    tick();
    chk({tag, "_pulse"}, 64'(regfile_wen), 64'd0);
  endtask

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    exp_instret = '0;
    last_addr   = '0;
    last_data   = '0;
    idle_inputs();

    // Reset with in_valid high
    rst = 1'b0;
    present(5'd9, 1'b1, 2'b00, 32'h55, 32'h66, 3'd0, 2'd0);
    tick();
    tick();
    chk("rst_ready", 64'(in_ready), 64'd0);
    chk("rst_wen", 64'(regfile_wen), 64'd0);
    chk("rst_outs", 64'({rd_addr_out, rd_data_out, pending_rd}), 64'd0);
    chk("rst_pend", 64'(load_pending), 64'd0);
`ifdef WB_RETIRE_CNT_EN
    chk("rst_instret", instret, 64'd0);
`endif
    idle_inputs();
    rst = 1'b1;
    tick();
    chk("rel_ready", 64'(in_ready), 64'd1);
    chk("rel_wen", 64'(regfile_wen), 64'd0);

    // Back-to-back ALU writes
    present(5'd5, 1'b1, 2'b00, 32'h1234, 32'h0, 3'd0, 2'd0);
    tick();
    present(5'd6, 1'b1, 2'b00, 32'hABCD, 32'h0, 3'd0, 2'd0);
    expect_write("b2b0", 5'd5, 1'b1, 32'h1234);
    chk("b2b0_ready", 64'(in_ready), 64'd1);
    tick();
    idle_inputs();
    expect_write("b2b1", 5'd6, 1'b1, 32'hABCD);
    chk("b2b1_ready", 64'(in_ready), 64'd1);
    exp_instret += 2;
    tick();
    chk("b2b_end", 64'(regfile_wen), 64'd0);
    chk("b2b_hold", 64'({rd_addr_out, rd_data_out}), 64'({5'd6, 32'hABCD}));

    // Directed loads with a 3-cycle wait
    do_load("lb",  5'd7, 1'b1, 3'b000, 2'd2, 32'h12F45678, 3);
    chk("lb_val", 64'(last_data), 64'hFFFFFFF4);
    do_load("lbu", 5'd7, 1'b1, 3'b100, 2'd2, 32'h12F45678, 3);
    chk("lbu_val", 64'(last_data), 64'h000000F4);
    do_load("lhu", 5'd7, 1'b1, 3'b101, 2'd2, 32'h12F45678, 3);
    chk("lhu_val", 64'(last_data), 64'h000012F4);
    do_load("lw0", 5'd8, 1'b1, 3'b010, 2'd0, 32'h89ABCDEF, 0);

    // JAL to x0 retires without writing
    do_nonload("jal_x0", 5'd0, 1'b1, 2'b10, 32'h11, 32'h2004);
`ifdef WB_RETIRE_CNT_EN
    chk("jal_instret", instret, exp_instret);
`endif

    // Reset while a load is pending abandons it
    present(5'd12, 1'b1, 2'b01, 32'h0, 32'h0, 3'b010, 2'd0);
    tick();
    idle_inputs();
    tick();
    chk("abort_pend", 64'({load_pending, pending_rd}), 64'({1'b1, 5'd12}));
    rst = 1'b0;
    tick();
    chk("abort_wen", 64'(regfile_wen), 64'd0);
    chk("abort_pend0", 64'({load_pending, pending_rd}), 64'd0);
    chk("abort_outs", 64'({rd_addr_out, rd_data_out}), 64'd0);
    exp_instret = '0;
    last_addr   = '0;
    last_data   = '0;
    rst = 1'b1;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'hCAFEF00D;
    tick();
    chk("abort_late_wen", 64'(regfile_wen), 64'd0);
    chk("abort_late_state", 64'({load_pending, in_ready}), 64'({1'b0, 1'b1}));

    // dmem_rvalid pulses in IDLE are ignored
    for (int i = 0; i < 3; i++) begin
      dmem_rvalid = 1'b1;
      dmem_rdata  = $urandom;
      tick();
      chk("idle_rv_wen", 64'(regfile_wen), 64'd0);
      chk("idle_rv_state", 64'({load_pending, in_ready}), 64'({1'b0, 1'b1}));
    end
    dmem_rvalid = 1'b0;
    tick();

    // Randomized instruction mix
    for (int i = 0; i < 40; i++) begin
      logic [4:0]  rd;
      logic        wen;
      logic [1:0]  sel;
      rd  = 5'($urandom_range(0, 31));
      wen = ($urandom_range(0, 3) != 0);
      sel = 2'($urandom);
      if (sel == 2'b01) begin
        do_load("rnd_ld", rd, wen, 3'($urandom), 2'($urandom), $urandom, $urandom_range(0, 4));
      end else begin
        do_nonload("rnd_nl", rd, wen, sel, $urandom, $urandom);
      end
    end

`ifdef WB_RETIRE_CNT_EN
    chk("final_instret", instret, exp_instret);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
